// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: latency encoding and RV32I opcodes.
package hazard_scoreboard_pkg;

  localparam int LAT_W = 3;

  typedef logic [LAT_W-1:0] hz_lat_t;

  localparam hz_lat_t LAT_UNBOUNDED = '1;
  localparam hz_lat_t LAT_LOAD      = hz_lat_t'(1);
  localparam hz_lat_t LAT_MUL       = hz_lat_t'(3);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/hazard_src_decode.sv
// Opcode -> register-source usage {use1, use2}; purely combinational so the
// forwarding unit can share it.
module hazard_src_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       use1_o,
  output logic       use2_o
);

  // Classify the opcode by which source fields it actually reads
  always_comb begin
    use1_o = 1'b1;
    use2_o = 1'b1;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        use1_o = 1'b0;
        use2_o = 1'b0;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        use1_o = 1'b1;
        use2_o = 1'b0;
      end
      default: begin
        use1_o = 1'b1;
        use2_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that raises bubble while ID reads a not-yet-forwardable
// register. Optional macro HAZARD_STORE_FWD_EN lets store data bypass a 1-cycle-away producer.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              pipe_adv,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              cmpl_valid,
  input  logic [4:0]        cmpl_rd,
  output logic              bubble,
  output logic [NUM_REGS-1:0] pending_vec,
  output logic [PERF_W-1:0] stall_cycles
);
  import hazard_scoreboard_pkg::*;

  localparam logic [LAT_W-1:0]  LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_UNB  = {LAT_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [4:0]          rs1_s, rs2_s;
  logic                use1_s, use2_s, use2_eff_s;
  logic                issue_fire_s;
  logic [NUM_REGS-1:0] pend_s;
  logic [PERF_W-1:0]   stall_q, stall_d;
  logic                unused_instr_s;

  assign rs1_s          = id_instr[19:15];
  assign rs2_s          = id_instr[24:20];
  assign unused_instr_s = ^{id_instr[31:25], id_instr[14:7]};

  hazard_src_decode u_src_decode (
    .opcode_i (id_instr[6:0]),
    .use1_o   (use1_s),
    .use2_o   (use2_s)
  );

  // A transfer only happens when the back end advances; x0 and latency 0 are never tracked
  assign issue_fire_s = issue_valid & pipe_adv & (issue_rd != 5'd0) & (issue_lat != LAT_ZERO);

`ifdef HAZARD_STORE_FWD_EN
  logic [NUM_REGS-1:0] one_s;
  assign one_s[0] = 1'b0;
`endif

  assign pend_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Issue beats completion beats countdown; unbounded entries wait for completion
    always_comb begin
      cnt_d = cnt_q;
      if (issue_fire_s && (issue_rd == 5'(r))) begin
        cnt_d = issue_lat;
      end else if (cmpl_valid && (cmpl_rd == 5'(r))) begin
        cnt_d = LAT_ZERO;
      end else if (pipe_adv && (cnt_q != LAT_ZERO) && (cnt_q != LAT_UNB)) begin
        cnt_d = cnt_q - LAT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Counter register
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= LAT_ZERO;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pend_s[r] = (cnt_q != LAT_ZERO);
`ifdef HAZARD_STORE_FWD_EN
    assign one_s[r]  = (cnt_q == LAT_ONE);
`endif
  end

`ifdef HAZARD_STORE_FWD_EN
  assign use2_eff_s = use2_s & ~((id_instr[6:0] == OPC_STORE) & one_s[rs2_s]);
`else
  assign use2_eff_s = use2_s;
`endif

  assign bubble = ~rst & id_valid & ~flush &
                  ((use1_s & pend_s[rs1_s]) | (use2_eff_s & pend_s[rs2_s]));

  assign pending_vec = pend_s;

  // Saturating stall-cycle performance counter
  always_comb begin
    stall_d = stall_q;
    if (bubble && (stall_q != PERF_MAX)) begin
      stall_d = stall_q + PERF_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= {PERF_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; expected values hand-derived per scenario.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        pipe_adv;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic        cmpl_valid;
  logic [4:0]  cmpl_rd;
  logic        bubble;
  logic [31:0] pending_vec;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(32), .LAT_W(3), .PERF_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .pipe_adv     (pipe_adv),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_lat    (issue_lat),
    .cmpl_valid   (cmpl_valid),
    .cmpl_rd      (cmpl_rd),
    .bubble       (bubble),
    .pending_vec  (pending_vec),
    .stall_cycles (stall_cycles)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] sw_instr(input logic [4:0] base, input logic [4:0] data);
    return {7'b0000000, data, base, 3'b010, 5'b00000, 7'b0100011};
  endfunction

  function automatic logic [31:0] lui_instr(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_valid    = 1'b0;
    id_instr    = 32'h0000_0013;
    pipe_adv    = 1'b1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    issue_lat   = 3'd0;
    cmpl_valid  = 1'b0;
    cmpl_rd     = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_lat   = lat;
    tick();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    issue_lat   = 3'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst      = 1'b0;
    id_valid = 1'b1;
    id_instr = r_type(5'd1, 5'd2, 5'd3);
    #1;
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble); end
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL reset_pending got %h want 0", pending_vec); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    idle();
  endtask

  task automatic test_load_use;
    issue(5'd5, 3'd1);
    id_valid = 1'b1;
    id_instr = r_type(5'd6, 5'd5, 5'd1);
    #1;
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", bubble); end
    tick();
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL load_use_release got %b want 0", bubble); end
    checks++;
    if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_stallcnt got %0d want 1", stall_cycles); end
    idle();
  endtask

  task automatic test_mul_chain;
    int n;
    issue(5'd7, 3'd3);
    id_valid = 1'b1;
    id_instr = r_type(5'd8, 5'd7, 5'd7);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bubble === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL mul_bubble_len got %0d want 3", n); end
    idle();
    issue(5'd7, 3'd3);
    id_valid = 1'b1;
    id_instr = r_type(5'd8, 5'd7, 5'd7);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      pipe_adv = (i != 1) && (i != 2);
      #1;
      if (bubble === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL mul_memstall_len got %0d want 5", n); end
    checks++;
    if (stall_cycles !== 32'd9) begin errors++; $display("FAIL mul_stallcnt got %0d want 9", stall_cycles); end
    idle();
  endtask

  task automatic test_unbounded;
    issue(5'd9, 3'd7);
    id_valid = 1'b1;
    id_instr = r_type(5'd10, 5'd9, 5'd0);
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (pending_vec[9] !== 1'b1) begin errors++; $display("FAIL unb_pending cyc %0d got %b want 1", i, pending_vec[9]); end
      checks++;
      if (bubble !== 1'b1) begin errors++; $display("FAIL unb_bubble cyc %0d got %b want 1", i, bubble); end
      tick();
    end
    cmpl_valid = 1'b1;
    cmpl_rd    = 5'd9;
    #1;
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL unb_cmpl_cycle got %b want 1", bubble); end
    tick();
    cmpl_valid = 1'b0;
    #1;
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL unb_after_cmpl got %b want 0", bubble); end
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL unb_pending_clear got %h want 0", pending_vec); end
    idle();
  endtask

  task automatic test_x0_nosrc;
    issue(5'd0, 3'd3);
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL x0_pending got %h want 0", pending_vec); end
    pipe_adv = 1'b0;
    issue(5'd11, 3'd2);
    pipe_adv = 1'b1;
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL noadv_issue got %h want 0", pending_vec); end
    issue(5'd5, 3'd3);
    checks++;
    if (pending_vec !== 32'h0000_0020) begin errors++; $display("FAIL x5_pending got %h want 00000020", pending_vec); end
    id_valid = 1'b1;
    id_instr = lui_instr(5'd4);
    #1;
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL lui_nosrc got %b want 0", bubble); end
    id_instr = r_type(5'd6, 5'd5, 5'd5);
    flush    = 1'b1;
    #1;
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL flush_bubble got %b want 0", bubble); end
    flush = 1'b0;
    #1;
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL after_flush got %b want 1", bubble); end
    idle();
    tick();
    tick();
    tick();
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL x5_drain got %h want 0", pending_vec); end
  endtask

  task automatic test_store;
    logic exp_data;
`ifdef HAZARD_STORE_FWD_EN
    exp_data = 1'b0;
`else
    exp_data = 1'b1;
`endif
    issue(5'd5, 3'd1);
    id_valid = 1'b1;
    id_instr = sw_instr(5'd2, 5'd5);
    #1;
    checks++;
    if (bubble !== exp_data) begin errors++; $display("FAIL store_data got %b want %b", bubble, exp_data); end
    id_instr = sw_instr(5'd5, 5'd2);
    #1;
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL store_addr got %b want 1", bubble); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    issue(5'd12, 3'd3);
    issue(5'd12, 3'd1);
    id_valid = 1'b1;
    id_instr = r_type(5'd13, 5'd0, 5'd12);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bubble === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL waw_younger_len got %0d want 1", n); end
    idle();
  endtask

  task automatic test_reset_midop;
    int n;
    issue(5'd9, 3'd7);
    issue(5'd7, 3'd3);
    checks++;
    if (pending_vec !== 32'h0000_0280) begin errors++; $display("FAIL midop_pending got %h want 00000280", pending_vec); end
    id_valid = 1'b1;
    id_instr = r_type(5'd1, 5'd7, 5'd9);
    #1;
    checks++;
    if (bubble !== 1'b1) begin errors++; $display("FAIL midop_bubble got %b want 1", bubble); end
    rst = 1'b1;
    #1;
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL rst_forces_bubble got %b want 0", bubble); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pending_vec !== 32'h0) begin errors++; $display("FAIL midop_rst_pending got %h want 0", pending_vec); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL midop_rst_stall got %0d want 0", stall_cycles); end
    checks++;
    if (bubble !== 1'b0) begin errors++; $display("FAIL midop_rst_bubble got %b want 0", bubble); end
    idle();
    cmpl_valid = 1'b1;
    cmpl_rd    = 5'd3;
    issue(5'd3, 3'd2);
    cmpl_valid = 1'b0;
    checks++;
    if (pending_vec !== 32'h0000_0008) begin errors++; $display("FAIL issue_cmpl_pending got %h want 00000008", pending_vec); end
    id_valid = 1'b1;
    id_instr = r_type(5'd1, 5'd3, 5'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bubble === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL issue_cmpl_len got %0d want 2", n); end
    checks++;
    if (stall_cycles !== 32'd2) begin errors++; $display("FAIL issue_cmpl_stallcnt got %0d want 2", stall_cycles); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul_chain();
    test_unbounded();
    test_x0_nosrc();
    test_store();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
